// File: rtl/warp_result_collector.sv
// Purpose : gathers per-thread results of one in-flight warp instruction into a single warp-wide writeback beat.
// Latency : beat is valid the cycle after the last pending lane is accepted; IDLE is re-entered the cycle after the beat is taken.
// Backpressure: one instruction at a time; issue_ready low while busy, cores stall on non-pending lanes, beat held until wb_ready.
// Optional timeout feature: define WB_TIMEOUT_EN to close a partial beat after TIMEOUT_CYCLES cycles in COLLECT.
module warp_result_collector #(
    parameter int NUM_THREADS    = 32,
    parameter int REG_WIDTH      = 32,
    parameter int WARP_ID_W      = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_valid,
    output logic                             issue_ready,
    input  logic [NUM_THREADS-1:0]           issue_mask,
    input  logic [4:0]                       issue_rd,
    input  logic [WARP_ID_W-1:0]             issue_warp_id,
    input  logic [NUM_THREADS-1:0]           core_result_valid,
    output logic [NUM_THREADS-1:0]           core_result_ready,
    input  logic [NUM_THREADS*REG_WIDTH-1:0] core_result,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic [NUM_THREADS-1:0]           wb_mask,
    output logic [NUM_THREADS*REG_WIDTH-1:0] wb_data,
    output logic [4:0]                       wb_rd,
    output logic [WARP_ID_W-1:0]             wb_warp_id,
    output logic                             wb_timeout,
    output logic                             busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COLLECT   = 2'd1,
        S_WRITEBACK = 2'd2
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;

    logic [NUM_THREADS-1:0]           r_pending;
    logic [NUM_THREADS-1:0]           r_expected;
    logic [NUM_THREADS*REG_WIDTH-1:0] r_buf;
    logic [4:0]                       r_rd;
    logic [WARP_ID_W-1:0]             r_warp_id;

    logic [NUM_THREADS-1:0]           w_lane_rdy;
    logic [NUM_THREADS-1:0]           w_accept;
    logic [NUM_THREADS-1:0]           w_pending_nxt;
    logic                             w_issue_take;
    logic                             w_wb_fire;
    logic                             w_timeout_hit;

    // Lane readiness depends only on state and pending, never on the core's valid.
    assign w_lane_rdy    = (r_state == S_COLLECT) ? r_pending : '0;
    assign w_accept      = core_result_valid & w_lane_rdy;
    assign w_pending_nxt = r_pending & ~w_accept;
    // A zero-mask issue is consumed in IDLE without starting a collection.
    assign w_issue_take  = (r_state == S_IDLE) && issue_valid && (issue_mask != '0);
    assign w_wb_fire     = (r_state == S_WRITEBACK) && wb_ready;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;
    logic             r_timeout;

    // Fires on the COLLECT cycle whose increment would make the count reach the limit.
    // A collection that completes on that same cycle is a normal, non-timeout beat.
    assign w_timeout_hit = (r_state == S_COLLECT)
                        && (r_count == CNT_W'(TIMEOUT_CYCLES - 1))
                        && (w_pending_nxt != '0);

    // Collect-phase cycle counter, restarted whenever a new collection begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_issue_take) begin
            r_count <= '0;
        end else if (r_state == S_COLLECT) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Marks a partial beat; cleared once the register file takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
        end else if (w_wb_fire) begin
            r_timeout <= 1'b0;
        end
    end

    assign wb_timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    // The limit has no effect in this build; the comparison folds to a constant 0.
    assign wb_timeout    = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake/beat outputs; beat fields are zero whenever no beat is offered.
    always_comb begin
        w_state_nxt       = r_state;
        issue_ready       = 1'b0;
        busy              = 1'b0;
        wb_valid          = 1'b0;
        wb_mask           = '0;
        wb_data           = '0;
        wb_rd             = '0;
        wb_warp_id        = '0;
        core_result_ready = w_lane_rdy;
        case (r_state)
            S_IDLE: begin
                issue_ready = 1'b1;
                if (w_issue_take) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                busy = 1'b1;
                if ((w_pending_nxt == '0) || w_timeout_hit) begin
                    w_state_nxt = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                busy       = 1'b1;
                wb_valid   = 1'b1;
                wb_mask    = r_expected;
                wb_data    = r_buf;
                wb_rd      = r_rd;
                wb_warp_id = r_warp_id;
                if (w_wb_fire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Instruction context and result buffer: loaded on issue, filled lane by lane during COLLECT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_expected <= '0;
            r_buf      <= '0;
            r_rd       <= '0;
            r_warp_id  <= '0;
        end else if (w_issue_take) begin
            r_pending  <= issue_mask;
            r_expected <= issue_mask;
            r_buf      <= '0;
            r_rd       <= issue_rd;
            r_warp_id  <= issue_warp_id;
        end else if (r_state == S_COLLECT) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (w_accept[i]) begin
                    r_buf[i*REG_WIDTH +: REG_WIDTH] <= core_result[i*REG_WIDTH +: REG_WIDTH];
                end
            end
            if (w_timeout_hit) begin
                // Lanes still outstanding are dropped and excluded from the written mask.
                r_expected <= r_expected & ~w_pending_nxt;
                r_pending  <= '0;
            end else begin
                r_pending  <= w_pending_nxt;
            end
        end
    end

endmodule

// File: tb/tb_warp_result_collector.sv
// Bench for warp_result_collector: directed scenarios plus randomized warps against a lane-level model.
// Expected beats are built from issued masks and per-lane return schedules.
// Define WB_TIMEOUT_EN to also exercise the timeout path with an 8-cycle limit.
module tb_warp_result_collector;

    localparam int N   = 32;
    localparam int W   = 32;
    localparam int WID = 5;
`ifdef WB_TIMEOUT_EN
    localparam int TO  = 8;
`else
    localparam int TO  = 1024;
`endif

    logic           clk;
    logic           rst;
    logic           issue_valid;
    logic           issue_ready;
    logic [N-1:0]   issue_mask;
    logic [4:0]     issue_rd;
    logic [WID-1:0] issue_warp_id;
    logic [N-1:0]   core_result_valid;
    logic [N-1:0]   core_result_ready;
    logic [N*W-1:0] core_result;
    logic           wb_valid;
    logic           wb_ready;
    logic [N-1:0]   wb_mask;
    logic [N*W-1:0] wb_data;
    logic [4:0]     wb_rd;
    logic [WID-1:0] wb_warp_id;
    logic           wb_timeout;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    warp_result_collector #(
        .NUM_THREADS(N), .REG_WIDTH(W), .WARP_ID_W(WID), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_mask(issue_mask),
        .issue_rd(issue_rd), .issue_warp_id(issue_warp_id),
        .core_result_valid(core_result_valid), .core_result_ready(core_result_ready),
        .core_result(core_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_mask(wb_mask), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_warp_id(wb_warp_id), .wb_timeout(wb_timeout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First lane where two packed warp vectors differ (0 if identical).
    function automatic int first_diff(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        for (int i = N - 1; i >= 0; i--) begin
            if (a[i*W +: W] !== b[i*W +: W]) first_diff = i;
        end
        if (a === b) first_diff = 0;
    endfunction

    task automatic idle_inputs();
        issue_valid       = 1'b0;
        issue_mask        = '0;
        issue_rd          = '0;
        issue_warp_id     = '0;
        core_result_valid = '0;
        core_result       = '0;
        wb_ready          = 1'b0;
    endtask

    // One-cycle issue; afterwards the DUT is in its first COLLECT cycle (for a nonzero mask).
    task automatic do_issue(input logic [N-1:0] m, input logic [4:0] rd, input logic [WID-1:0] wid);
        issue_valid   = 1'b1;
        issue_mask    = m;
        issue_rd      = rd;
        issue_warp_id = wid;
        tick();
        issue_valid   = 1'b0;
        issue_mask    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if ({wb_valid, wb_timeout, busy, issue_ready} !== 4'b0001) begin n_err++;
            $display("FAIL reset_ctrl got v/t/busy/ir=%b want 0001", {wb_valid, wb_timeout, busy, issue_ready}); end
        n_vec++; if ({wb_mask, wb_rd, wb_warp_id, core_result_ready} !== '0) begin n_err++;
            $display("FAIL reset_fields got mask=%h rd=%0d wid=%0d crr=%h want 0", wb_mask, wb_rd, wb_warp_id, core_result_ready); end
        n_vec++; if (wb_data !== '0) begin n_err++;
            $display("FAIL reset_data lane %0d got %h want 0", first_diff(wb_data, '0), wb_data[first_diff(wb_data, '0)*W +: W]); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_warp();
        logic [N*W-1:0] exp_data;
        do_issue(32'hFFFF_FFFF, 5'd7, 5'd3);
        n_vec++; if (core_result_ready !== 32'hFFFF_FFFF) begin n_err++;
            $display("FAIL full_ready got %h want ffffffff", core_result_ready); end
        for (int i = 0; i < N; i++) begin
            core_result[i*W +: W] = W'(i + 100);
            exp_data[i*W +: W]    = W'(i + 100);
        end
        core_result_valid = '1;
        tick();
        core_result_valid = '0;
        n_vec++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL full_valid got %b want 1", wb_valid); end
        n_vec++; if (wb_mask !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL full_mask got %h want ffffffff", wb_mask); end
        n_vec++; if (wb_data !== exp_data) begin n_err++;
            $display("FAIL full_data lane %0d got %h want %h", first_diff(wb_data, exp_data),
                     wb_data[first_diff(wb_data, exp_data)*W +: W], exp_data[first_diff(wb_data, exp_data)*W +: W]); end
        n_vec++; if ({wb_rd, wb_warp_id, wb_timeout} !== {5'd7, 5'd3, 1'b0}) begin n_err++;
            $display("FAIL full_ids got rd=%0d wid=%0d to=%b want 7 3 0", wb_rd, wb_warp_id, wb_timeout); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        n_vec++; if ({issue_ready, wb_valid, busy} !== 3'b100) begin n_err++;
            $display("FAIL full_release got ir/v/busy=%b want 100", {issue_ready, wb_valid, busy}); end
        n_vec++; if ({wb_mask, wb_rd, wb_warp_id} !== '0 || wb_data !== '0) begin n_err++;
            $display("FAIL full_zeroed got mask=%h rd=%0d wid=%0d want 0", wb_mask, wb_rd, wb_warp_id); end
    endtask

    task automatic test_staggered();
        logic [N*W-1:0] exp_data;
        exp_data = '0;
        do_issue(32'h0000_00F0, 5'd2, 5'd9);
        core_result_valid[2]  = 1'b1;
        core_result[2*W +: W] = 32'hDEAD_BEEF;
        for (int j = 0; j < 4; j++) begin
            core_result_valid[4+j]    = 1'b1;
            core_result[(4+j)*W +: W] = W'(32'hA0 + j);
            exp_data[(4+j)*W +: W]    = W'(32'hA0 + j);
            n_vec++; if (core_result_ready[2] !== 1'b0) begin n_err++; $display("FAIL stag_lane2_ready step %0d got 1 want 0", j); end
            n_vec++; if (core_result_ready[4+j] !== 1'b1) begin n_err++; $display("FAIL stag_lane_ready step %0d got 0 want 1", j); end
            tick();
            core_result_valid[4+j] = 1'b0;
            n_vec++; if (wb_valid !== (j == 3)) begin n_err++; $display("FAIL stag_valid step %0d got %b want %b", j, wb_valid, (j == 3)); end
        end
        core_result_valid = '0;
        n_vec++; if (wb_mask !== 32'h0000_00F0) begin n_err++; $display("FAIL stag_mask got %h want 000000f0", wb_mask); end
        n_vec++; if (wb_data !== exp_data) begin n_err++;
            $display("FAIL stag_data lane %0d got %h want %h", first_diff(wb_data, exp_data),
                     wb_data[first_diff(wb_data, exp_data)*W +: W], exp_data[first_diff(wb_data, exp_data)*W +: W]); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic test_zero_mask();
        do_issue('0, 5'd11, 5'd4);
        core_result_valid = '1;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if ({wb_valid, issue_ready, busy, core_result_ready} !== {1'b0, 1'b1, 1'b0, {N{1'b0}}}) begin n_err++;
                $display("FAIL zero_mask cyc %0d got v/ir/busy=%b%b%b crr=%h want 010 0", k, wb_valid, issue_ready, busy, core_result_ready); end
            tick();
        end
        core_result_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [N-1:0]   m;
        logic [N*W-1:0] vals;
        logic [N*W-1:0] exp_data;
        m = $urandom | 32'h1;
        for (int i = 0; i < N; i++) begin
            vals[i*W +: W]     = $urandom;
            exp_data[i*W +: W] = m[i] ? vals[i*W +: W] : '0;
        end
        do_issue(m, 5'd21, 5'd17);
        core_result       = vals;
        core_result_valid = m;
        tick();
        core_result_valid = '1;
        for (int k = 0; k < 5; k++) begin
            core_result = {N{W'($urandom)}};
            n_vec++; if ({wb_valid, issue_ready, core_result_ready} !== {1'b1, 1'b0, {N{1'b0}}}) begin n_err++;
                $display("FAIL bp_ctrl cyc %0d got v=%b ir=%b crr=%h want 1 0 0", k, wb_valid, issue_ready, core_result_ready); end
            n_vec++; if ({wb_mask, wb_rd, wb_warp_id} !== {m, 5'd21, 5'd17}) begin n_err++;
                $display("FAIL bp_fields cyc %0d got mask=%h rd=%0d wid=%0d want %h 21 17", k, wb_mask, wb_rd, wb_warp_id, m); end
            n_vec++; if (wb_data !== exp_data) begin n_err++;
                $display("FAIL bp_data cyc %0d lane %0d got %h want %h", k, first_diff(wb_data, exp_data),
                         wb_data[first_diff(wb_data, exp_data)*W +: W], exp_data[first_diff(wb_data, exp_data)*W +: W]); end
            tick();
        end
        core_result_valid = '0;
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        n_vec++; if ({issue_ready, wb_valid, busy} !== 3'b100) begin n_err++;
            $display("FAIL bp_release got ir/v/busy=%b want 100", {issue_ready, wb_valid, busy}); end
    endtask

    task automatic test_reset_mid_collect();
        logic [N*W-1:0] exp_data;
        do_issue(32'h0000_000F, 5'd5, 5'd6);
        core_result_valid     = 32'h0000_0003;
        core_result[0*W +: W] = 32'h1111_1111;
        core_result[1*W +: W] = 32'h2222_2222;
        tick();
        core_result_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if ({wb_valid, wb_timeout, busy, issue_ready} !== 4'b0001) begin n_err++;
            $display("FAIL rstmid_ctrl got v/t/busy/ir=%b want 0001", {wb_valid, wb_timeout, busy, issue_ready}); end
        n_vec++; if ({wb_mask, wb_rd, wb_warp_id, core_result_ready} !== '0 || wb_data !== '0) begin n_err++;
            $display("FAIL rstmid_fields got mask=%h rd=%0d wid=%0d crr=%h want 0", wb_mask, wb_rd, wb_warp_id, core_result_ready); end
        core_result_valid = 32'h0000_000C;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if ({wb_valid, busy, core_result_ready} !== '0) begin n_err++;
                $display("FAIL rstmid_nobeat cyc %0d got v=%b busy=%b crr=%h want 0", k, wb_valid, busy, core_result_ready); end
            tick();
        end
        core_result_valid = '0;
        do_issue(32'h0000_0001, 5'd1, 5'd2);
        n_vec++; if ({busy, core_result_ready} !== {1'b1, 32'h0000_0001}) begin n_err++;
            $display("FAIL rstmid_reissue got busy=%b crr=%h want 1 00000001", busy, core_result_ready); end
        core_result_valid     = 32'h0000_0003;
        core_result[0*W +: W] = 32'h3333_3333;
        exp_data              = '0;
        exp_data[0*W +: W]    = 32'h3333_3333;
        tick();
        core_result_valid = '0;
        n_vec++; if ({wb_valid, wb_mask} !== {1'b1, 32'h0000_0001} || wb_data !== exp_data) begin n_err++;
            $display("FAIL rstmid_beat got v=%b mask=%h lane%0d=%h", wb_valid, wb_mask, first_diff(wb_data, exp_data),
                     wb_data[first_diff(wb_data, exp_data)*W +: W]); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    // Random warps: each active lane returns once, at a random delay; idle lanes spray noise.
    task automatic test_random();
        logic [N-1:0]   m;
        logic [N-1:0]   exp_rdy;
        logic [W-1:0]   val [N];
        int             d   [N];
        int             maxd;
        logic [4:0]     rd;
        logic [WID-1:0] wid;
        logic [N*W-1:0] exp_data;
        for (int it = 0; it < 40; it++) begin
            m = $urandom;
            if ($urandom_range(0, 3) == 0) m = m & $urandom & $urandom;
            if (m == '0) m[$urandom_range(0, N-1)] = 1'b1;
            rd   = 5'($urandom);
            wid  = WID'($urandom);
            maxd = 0;
            exp_data = '0;
            for (int i = 0; i < N; i++) begin
                val[i] = $urandom;
                d[i]   = $urandom_range(0, 6);
                if (m[i]) begin
                    exp_data[i*W +: W] = val[i];
                    if (d[i] > maxd) maxd = d[i];
                end
            end
            do_issue(m, rd, wid);
            for (int k = 0; k <= maxd; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (m[i]) begin
                        core_result_valid[i] = (k >= d[i]);
                        core_result[i*W +: W] = (k >= d[i]) ? val[i] : W'($urandom);
                        exp_rdy[i] = (k <= d[i]);
                    end else begin
                        core_result_valid[i] = 1'($urandom);
                        core_result[i*W +: W] = $urandom;
                        exp_rdy[i] = 1'b0;
                    end
                end
                n_vec++; if (core_result_ready !== exp_rdy) begin n_err++;
                    $display("FAIL rand_ready it %0d cyc %0d got %h want %h", it, k, core_result_ready, exp_rdy); end
                tick();
                n_vec++; if (wb_valid !== (k == maxd)) begin n_err++;
                    $display("FAIL rand_valid it %0d cyc %0d got %b want %b", it, k, wb_valid, (k == maxd)); end
            end
            core_result_valid = '0;
            for (int h = $urandom_range(0, 3); h >= 0; h--) begin
                n_vec++; if ({wb_mask, wb_rd, wb_warp_id, wb_timeout, issue_ready} !== {m, rd, wid, 1'b0, 1'b0}) begin n_err++;
                    $display("FAIL rand_fields it %0d got mask=%h rd=%0d wid=%0d to=%b ir=%b want %h %0d %0d 0 0",
                             it, wb_mask, wb_rd, wb_warp_id, wb_timeout, issue_ready, m, rd, wid); end
                n_vec++; if (wb_data !== exp_data) begin n_err++;
                    $display("FAIL rand_data it %0d lane %0d got %h want %h", it, first_diff(wb_data, exp_data),
                             wb_data[first_diff(wb_data, exp_data)*W +: W], exp_data[first_diff(wb_data, exp_data)*W +: W]); end
                wb_ready = (h == 0);
                tick();
            end
            wb_ready = 1'b0;
            n_vec++; if ({issue_ready, wb_valid, busy} !== 3'b100) begin n_err++;
                $display("FAIL rand_release it %0d got ir/v/busy=%b want 100", it, {issue_ready, wb_valid, busy}); end
        end
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        logic [N*W-1:0] exp_data;
        exp_data           = '0;
        exp_data[0*W +: W] = 32'h0BAD_CAFE;
        do_issue(32'h0000_0003, 5'd12, 5'd8);
        core_result_valid     = 32'h0000_0001;
        core_result[0*W +: W] = 32'h0BAD_CAFE;
        for (int k = 0; k < TO; k++) begin
            tick();
            core_result_valid = '0;
            n_vec++; if (wb_valid !== (k == TO - 1)) begin n_err++;
                $display("FAIL to_valid cyc %0d got %b want %b", k, wb_valid, (k == TO - 1)); end
        end
        n_vec++; if ({wb_mask, wb_timeout} !== {32'h0000_0001, 1'b1}) begin n_err++;
            $display("FAIL to_beat got mask=%h to=%b want 00000001 1", wb_mask, wb_timeout); end
        n_vec++; if (wb_data !== exp_data) begin n_err++;
            $display("FAIL to_data lane %0d got %h", first_diff(wb_data, exp_data), wb_data[first_diff(wb_data, exp_data)*W +: W]); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        n_vec++; if ({wb_timeout, issue_ready} !== 2'b01) begin n_err++;
            $display("FAIL to_clear got to/ir=%b want 01", {wb_timeout, issue_ready}); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_full_warp();
        test_staggered();
        test_zero_mask();
        test_backpressure();
        test_reset_mid_collect();
        test_random();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
